// File: rtl/cvxif_compressed_req_sequencer.sv
// Sequences CV-X-IF compressed offload requests from up to two decode lanes onto one coprocessor port.
// Latency: capture in IDLE, one REQ cycle per lane (plus ready-low cycles), results pulse in DONE.
// Backpressure: request held bit-stable while compressed_ready_i is low; stall_o holds decode meanwhile.
//
// Ports: clk_i/rst_ni (sync active-low), hart_id_i, lane_valid_i/lane_instr_i/flush_i from decode,
// stall_o to frontend, compressed_valid_o/compressed_req_o/compressed_ready_i/compressed_resp_i to the
// coprocessor, result_valid_o/result_accept_o/result_instr_o back to decode, timeout_o watchdog pulse.
// Optional macro CVXIF_COMPRESSED_TIMEOUT_EN adds a watchdog that abandons a lane after TIMEOUT_CYCLES.
module cvxif_compressed_req_sequencer #(
    parameter int unsigned HART_ID_W      = 32,
    parameter bit          SUPERSCALAR    = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [HART_ID_W-1:0]   hart_id_i,
    input  logic [1:0]             lane_valid_i,
    input  logic [31:0]            lane_instr_i,
    input  logic                   flush_i,
    output logic                   stall_o,
    output logic                   compressed_valid_o,
    output logic [16+HART_ID_W-1:0] compressed_req_o,
    input  logic                   compressed_ready_i,
    input  logic [32:0]            compressed_resp_i,
    output logic                   result_valid_o,
    output logic [1:0]             result_accept_o,
    output logic [63:0]            result_instr_o,
    output logic                   timeout_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state_q;
    logic [1:0][15:0]     instr_q;
    logic [HART_ID_W-1:0] hartid_q;
    logic [1:0]           pend_q;
    logic                 cur_q;
    logic                 flushed_q;
    logic [1:0]           res_accept_q;
    logic [1:0][31:0]     res_instr_q;

    logic [1:0]  pending;
    logic        in_req;
    logic        capture;
    logic        handshake;
    logic        advance;
    logic        timeout;
    logic [1:0]  cur_mask;
    logic [1:0]  remaining;
    logic [31:0] resp_instr;
    logic        resp_accept;

    assign pending     = lane_valid_i & {SUPERSCALAR, 1'b1};
    assign in_req      = (state_q == S_REQ);
    assign capture     = (state_q == S_IDLE) && (pending != 2'b00) && !flush_i;
    assign handshake   = in_req && compressed_ready_i;
    assign advance     = handshake || timeout;
    assign cur_mask    = 2'b01 << cur_q;
    assign remaining   = pend_q & ~cur_mask;
    assign resp_instr  = compressed_resp_i[32:1];
    assign resp_accept = compressed_resp_i[0];

`ifdef CVXIF_COMPRESSED_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q;

    // The cycle that would bring the count to TIMEOUT_CYCLES is the one that gives up.
    assign timeout = in_req && !compressed_ready_i
                     && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wait_cnt_q <= '0;
        end else if (capture || advance) begin
            // Covers entry into REQ and every lane switch.
            wait_cnt_q <= '0;
        end else if (in_req && !compressed_ready_i) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign timeout_o          = timeout;
    assign compressed_valid_o = in_req;
    // Driven from captured registers only so the request cannot wobble with decode inputs.
    assign compressed_req_o   = in_req ? {instr_q[cur_q], hartid_q} : '0;
    assign stall_o            = in_req || capture;
    assign result_valid_o     = (state_q == S_DONE) && !flushed_q && !flush_i;
    assign result_accept_o    = res_accept_q;
    assign result_instr_o     = res_instr_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            instr_q      <= '0;
            hartid_q     <= '0;
            pend_q       <= '0;
            cur_q        <= 1'b0;
            flushed_q    <= 1'b0;
            res_accept_q <= '0;
            res_instr_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (capture) begin
                        instr_q      <= lane_instr_i;
                        hartid_q     <= hart_id_i;
                        pend_q       <= pending;
                        cur_q        <= ~pending[0];
                        flushed_q    <= 1'b0;
                        // Non-pending lanes report their raw parcel, not accepted.
                        res_accept_q <= 2'b00;
                        res_instr_q  <= {16'h0000, lane_instr_i[31:16],
                                         16'h0000, lane_instr_i[15:0]};
                        state_q      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (flush_i) begin
                        flushed_q <= 1'b1;
                    end
                    if (advance) begin
                        res_accept_q[cur_q] <= handshake && resp_accept;
                        res_instr_q[cur_q]  <= (handshake && resp_accept)
                                               ? resp_instr
                                               : {16'h0000, instr_q[cur_q]};
                        pend_q[cur_q]       <= 1'b0;
                        // Lane 0 always goes first, so only lane 1 can remain.
                        if (remaining != 2'b00) begin
                            cur_q <= remaining[1];
                        end else begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (flush_i) begin
                        flushed_q <= 1'b1;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cvxif_compressed_req_sequencer.sv
module tb_cvxif_compressed_req_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] hart_id;
    logic [1:0]  lane_valid;
    logic [31:0] lane_instr;
    logic        flush;
    logic        ready;
    logic [32:0] resp;

    logic        stall, cvld, rvld, tmo;
    logic [47:0] creq;
    logic [1:0]  racc;
    logic [63:0] rinstr;

    logic        stall0, cvld0, rvld0, tmo0;
    logic [47:0] creq0;
    logic [1:0]  racc0;
    logic [63:0] rinstr0;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    cvxif_compressed_req_sequencer #(.HART_ID_W(32), .SUPERSCALAR(1'b1), .TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .hart_id_i(hart_id), .lane_valid_i(lane_valid),
        .lane_instr_i(lane_instr), .flush_i(flush), .stall_o(stall), .compressed_valid_o(cvld),
        .compressed_req_o(creq), .compressed_ready_i(ready), .compressed_resp_i(resp),
        .result_valid_o(rvld), .result_accept_o(racc), .result_instr_o(rinstr), .timeout_o(tmo)
    );

    cvxif_compressed_req_sequencer #(.HART_ID_W(32), .SUPERSCALAR(1'b0), .TIMEOUT_CYCLES(4)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .hart_id_i(hart_id), .lane_valid_i(lane_valid),
        .lane_instr_i(lane_instr), .flush_i(flush), .stall_o(stall0), .compressed_valid_o(cvld0),
        .compressed_req_o(creq0), .compressed_ready_i(ready), .compressed_resp_i(resp),
        .result_valid_o(rvld0), .result_accept_o(racc0), .result_instr_o(rinstr0), .timeout_o(tmo0)
    );

    // Inputs change on the falling edge; outputs are checked 1ns later, far from the rising edge.
    task automatic test_reset();
        rst_n = 1'b0; hart_id = '0; lane_valid = '0; lane_instr = '0;
        flush = 1'b0; ready = 1'b0; resp = '0;
        @(negedge clk); @(negedge clk); #1;
        if (cvld !== 1'b0)   begin errs++; $display("FAIL reset.valid got=%b exp=0", cvld); end vecs++;
        if (stall !== 1'b0)  begin errs++; $display("FAIL reset.stall got=%b exp=0", stall); end vecs++;
        if (creq !== 48'h0)  begin errs++; $display("FAIL reset.req got=%h exp=0", creq); end vecs++;
        if (rvld !== 1'b0)   begin errs++; $display("FAIL reset.rvalid got=%b exp=0", rvld); end vecs++;
        if (racc !== 2'b00)  begin errs++; $display("FAIL reset.accept got=%b exp=00", racc); end vecs++;
        if (rinstr !== 64'h0) begin errs++; $display("FAIL reset.rinstr got=%h exp=0", rinstr); end vecs++;
        if (tmo !== 1'b0)    begin errs++; $display("FAIL reset.timeout got=%b exp=0", tmo); end vecs++;
    endtask

    task automatic test_single_lane();
        @(negedge clk);
        rst_n = 1'b1; lane_valid = 2'b01; lane_instr = 32'h0000_4501; hart_id = 32'd3;
        ready = 1'b1; resp = {32'h0000_0513, 1'b1}; #1;
        if (stall !== 1'b1) begin errs++; $display("FAIL single.cap_stall got=%b exp=1", stall); end vecs++;
        if (cvld !== 1'b0)  begin errs++; $display("FAIL single.cap_valid got=%b exp=0", cvld); end vecs++;
        @(negedge clk); lane_valid = 2'b00; #1;
        if (cvld !== 1'b1)  begin errs++; $display("FAIL single.req_valid got=%b exp=1", cvld); end vecs++;
        if (creq !== {16'h4501, 32'd3}) begin errs++; $display("FAIL single.req got=%h exp=%h", creq, {16'h4501, 32'd3}); end vecs++;
        if (stall !== 1'b1) begin errs++; $display("FAIL single.req_stall got=%b exp=1", stall); end vecs++;
        @(negedge clk); #1;
        if (rvld !== 1'b1)  begin errs++; $display("FAIL single.rvalid got=%b exp=1", rvld); end vecs++;
        if (racc !== 2'b01) begin errs++; $display("FAIL single.accept got=%b exp=01", racc); end vecs++;
        if (rinstr !== 64'h0000_0000_0000_0513) begin errs++; $display("FAIL single.rinstr got=%h exp=%h", rinstr, 64'h513); end vecs++;
        if (stall !== 1'b0) begin errs++; $display("FAIL single.done_stall got=%b exp=0", stall); end vecs++;
        if (cvld !== 1'b0)  begin errs++; $display("FAIL single.done_valid got=%b exp=0", cvld); end vecs++;
        @(negedge clk); #1;
        if (rvld !== 1'b0)  begin errs++; $display("FAIL single.rvalid_pulse got=%b exp=0", rvld); end vecs++;
        if (racc !== 2'b01) begin errs++; $display("FAIL single.accept_hold got=%b exp=01", racc); end vecs++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        lane_valid = 2'b11; lane_instr = {16'h8082, 16'h4501}; hart_id = 32'd5; ready = 1'b0; #1;
        if (stall !== 1'b1) begin errs++; $display("FAIL b2b.cap_stall got=%b exp=1", stall); end vecs++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); lane_valid = 2'b00;
            if (i == 2) begin ready = 1'b1; resp = {32'h0000_0513, 1'b1}; end
            #1;
            if (cvld !== 1'b1) begin errs++; $display("FAIL b2b.lane0_valid[%0d] got=%b exp=1", i, cvld); end vecs++;
            if (creq !== {16'h4501, 32'd5}) begin errs++; $display("FAIL b2b.lane0_req[%0d] got=%h exp=%h", i, creq, {16'h4501, 32'd5}); end vecs++;
        end
        @(negedge clk); resp = {32'h0000_8067, 1'b1}; #1;
        if (cvld !== 1'b1) begin errs++; $display("FAIL b2b.lane1_valid got=%b exp=1", cvld); end vecs++;
        if (creq !== {16'h8082, 32'd5}) begin errs++; $display("FAIL b2b.lane1_req got=%h exp=%h", creq, {16'h8082, 32'd5}); end vecs++;
        @(negedge clk); ready = 1'b0; #1;
        if (rvld !== 1'b1)  begin errs++; $display("FAIL b2b.rvalid got=%b exp=1", rvld); end vecs++;
        if (racc !== 2'b11) begin errs++; $display("FAIL b2b.accept got=%b exp=11", racc); end vecs++;
        if (rinstr !== 64'h0000_8067_0000_0513) begin errs++; $display("FAIL b2b.rinstr got=%h exp=%h", rinstr, 64'h0000_8067_0000_0513); end vecs++;
        @(negedge clk); #1;
        if (rvld !== 1'b0)  begin errs++; $display("FAIL b2b.rvalid_pulse got=%b exp=0", rvld); end vecs++;
    endtask

    task automatic test_lane1_mask();
        @(negedge clk);
        lane_valid = 2'b10; lane_instr = {16'h4501, 16'h0000}; ready = 1'b1; resp = {32'h0, 1'b0}; #1;
        if (stall0 !== 1'b0) begin errs++; $display("FAIL mask.stall got=%b exp=0", stall0); end vecs++;
        if (stall !== 1'b1)  begin errs++; $display("FAIL mask.ss_stall got=%b exp=1", stall); end vecs++;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin @(negedge clk); lane_valid = 2'b00; #1; end
            if (cvld0 !== 1'b0) begin errs++; $display("FAIL mask.valid[%0d] got=%b exp=0", i, cvld0); end vecs++;
            if (rvld0 !== 1'b0) begin errs++; $display("FAIL mask.rvalid[%0d] got=%b exp=0", i, rvld0); end vecs++;
        end
        @(negedge clk); #1;
    endtask

    task automatic test_reject();
        @(negedge clk);
        lane_valid = 2'b01; lane_instr = {16'h1234, 16'h4501}; hart_id = 32'd3;
        ready = 1'b1; resp = {32'h0000_0513, 1'b0};
        @(negedge clk); lane_valid = 2'b00;
        @(negedge clk); #1;
        if (rvld !== 1'b1)  begin errs++; $display("FAIL reject.rvalid got=%b exp=1", rvld); end vecs++;
        if (racc !== 2'b00) begin errs++; $display("FAIL reject.accept got=%b exp=00", racc); end vecs++;
        if (rinstr !== 64'h0000_1234_0000_4501) begin errs++; $display("FAIL reject.rinstr got=%h exp=%h", rinstr, 64'h0000_1234_0000_4501); end vecs++;
        @(negedge clk); #1;
    endtask

    task automatic test_flush();
        @(negedge clk);
        lane_valid = 2'b01; lane_instr = 32'h0000_4501; ready = 1'b0; resp = {32'h0000_0513, 1'b1};
        @(negedge clk); lane_valid = 2'b00; flush = 1'b1; #1;
        if (cvld !== 1'b1) begin errs++; $display("FAIL flush.valid_at_flush got=%b exp=1", cvld); end vecs++;
        @(negedge clk); flush = 1'b0; #1;
        if (cvld !== 1'b1) begin errs++; $display("FAIL flush.valid_held got=%b exp=1", cvld); end vecs++;
        if (creq !== {16'h4501, 32'd3}) begin errs++; $display("FAIL flush.req_held got=%h exp=%h", creq, {16'h4501, 32'd3}); end vecs++;
        if (tmo !== 1'b0)  begin errs++; $display("FAIL flush.timeout got=%b exp=0", tmo); end vecs++;
        @(negedge clk); ready = 1'b1; #1;
        if (cvld !== 1'b1) begin errs++; $display("FAIL flush.valid_hs got=%b exp=1", cvld); end vecs++;
        @(negedge clk); ready = 1'b0; #1;
        if (rvld !== 1'b0)  begin errs++; $display("FAIL flush.rvalid got=%b exp=0", rvld); end vecs++;
        if (stall !== 1'b0) begin errs++; $display("FAIL flush.done_stall got=%b exp=0", stall); end vecs++;
        @(negedge clk);
        lane_valid = 2'b01; lane_instr = 32'h0000_4502; ready = 1'b1; resp = {32'h0000_0613, 1'b1};
        @(negedge clk); lane_valid = 2'b00; #1;
        if (creq !== {16'h4502, 32'd3}) begin errs++; $display("FAIL flush.next_req got=%h exp=%h", creq, {16'h4502, 32'd3}); end vecs++;
        @(negedge clk); #1;
        if (rvld !== 1'b1)  begin errs++; $display("FAIL flush.next_rvalid got=%b exp=1", rvld); end vecs++;
        if (rinstr[31:0] !== 32'h0000_0613) begin errs++; $display("FAIL flush.next_rinstr got=%h exp=00000613", rinstr[31:0]); end vecs++;
        @(negedge clk); ready = 1'b0; #1;
    endtask

`ifdef CVXIF_COMPRESSED_TIMEOUT_EN
    task automatic test_timeout();
        @(negedge clk);
        lane_valid = 2'b01; lane_instr = 32'h0000_4501; ready = 1'b0; resp = {32'h0000_0513, 1'b1};
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk); lane_valid = 2'b00; #1;
            if (tmo !== (i == 4)) begin errs++; $display("FAIL timeout.pulse[%0d] got=%b exp=%b", i, tmo, (i == 4)); end vecs++;
        end
        @(negedge clk); #1;
        if (rvld !== 1'b1)  begin errs++; $display("FAIL timeout.rvalid got=%b exp=1", rvld); end vecs++;
        if (racc !== 2'b00) begin errs++; $display("FAIL timeout.accept got=%b exp=00", racc); end vecs++;
        if (rinstr[31:0] !== 32'h0000_4501) begin errs++; $display("FAIL timeout.rinstr got=%h exp=00004501", rinstr[31:0]); end vecs++;
        if (tmo !== 1'b0)   begin errs++; $display("FAIL timeout.after got=%b exp=0", tmo); end vecs++;
        @(negedge clk); #1;
    endtask
`endif

    task automatic test_reset_mid_req();
        @(negedge clk);
        lane_valid = 2'b01; lane_instr = 32'h0000_4501; ready = 1'b0;
        @(negedge clk); lane_valid = 2'b00; #1;
        if (cvld !== 1'b1) begin errs++; $display("FAIL rstmid.valid_before got=%b exp=1", cvld); end vecs++;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); #1;
        if (cvld !== 1'b0)   begin errs++; $display("FAIL rstmid.valid got=%b exp=0", cvld); end vecs++;
        if (creq !== 48'h0)  begin errs++; $display("FAIL rstmid.req got=%h exp=0", creq); end vecs++;
        if (stall !== 1'b0)  begin errs++; $display("FAIL rstmid.stall got=%b exp=0", stall); end vecs++;
        if (racc !== 2'b00)  begin errs++; $display("FAIL rstmid.accept got=%b exp=00", racc); end vecs++;
        if (rinstr !== 64'h0) begin errs++; $display("FAIL rstmid.rinstr got=%h exp=0", rinstr); end vecs++;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            if (rvld !== 1'b0) begin errs++; $display("FAIL rstmid.no_result[%0d] got=%b exp=0", i, rvld); end vecs++;
        end
    endtask

    initial begin
        test_reset();
        test_single_lane();
        test_back_to_back();
        test_lane1_mask();
        test_reject();
        test_flush();
`ifdef CVXIF_COMPRESSED_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_req();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
